// File: rtl/l2_mem_pkg.sv
// Shared definitions for the L2-to-MainMemory posted-write path.
// Defaults here must stay in step with the L2 controller and MainMemory.
package l2_mem_pkg;

  localparam int L2_ADDR_W = 32;
  localparam int L2_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RESP = 2'd3
  } wb_state_t;

endpackage

// File: rtl/l2_mem_write_buffer_wb_fifo_cam.sv
// Write-buffer storage: circular FIFO with a parallel address compare and youngest-match select.
// With L2WB_COALESCE_EN defined, adds an in-place data overwrite port for matching entries.
module wb_fifo_cam #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_addr,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  input  logic [ADDR_W-1:0]       match_addr,
`ifdef L2WB_COALESCE_EN
  input  logic                    head_busy,
  input  logic                    ovr,
  input  logic [DATA_W-1:0]       ovr_data,
  output logic                    coal_hit,
  output logic                    coal_head,
`endif
  output logic [ADDR_W-1:0]       head_addr,
  output logic [DATA_W-1:0]       head_data,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    hit,
  output logic [DATA_W-1:0]       hit_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW-1:0]     idx;
`ifdef L2WB_COALESCE_EN
  logic [PW-1:0]     coal_idx;
`endif

  assign head_addr = addr_q[head];
  assign head_data = data_q[head];
  assign full      = (count == CW'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail] <= push_addr;
        data_q[tail] <= push_data;
        tail         <= tail + 1'b1;
      end
`ifdef L2WB_COALESCE_EN
      if (ovr) data_q[coal_idx] <= ovr_data;
`endif
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
`ifdef L2WB_COALESCE_EN
    coal_hit  = 1'b0;
    coal_head = 1'b0;
    coal_idx  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (addr_q[idx] == match_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
`ifdef L2WB_COALESCE_EN
        if (!(k == 0 && head_busy)) begin
          coal_hit  = 1'b1;
          coal_head = (k == 0);
          coal_idx  = idx;
        end
`endif
      end
    end
  end

endmodule

// File: rtl/l2_mem_write_buffer.sv
// Posted-write buffer between L2 and MainMemory: in-order drain, read forwarding, reads ahead of drains.
// Optional L2WB_COALESCE_EN merges writes into a matching entry that is not in flight.
//
// state   | meaning
// IDLE    | no memory transaction; choose read (priority) or head drain
// WR      | head write in flight, waiting for mem_stb
// RD      | pending read miss in flight, waiting for mem_stb
// RESP    | rsp_valid high with captured read data
module l2_mem_write_buffer
  import l2_mem_pkg::*;
#(
  parameter int ADDR_W = L2_ADDR_W,
  parameter int DATA_W = L2_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    mem_addrstb,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_stb,
  output logic [$clog2(DEPTH):0]  count
);

  wb_state_t         state, state_nx;
  logic              rd_pend;
  logic [ADDR_W-1:0] rd_addr;
  logic              full, hit;
  logic [DATA_W-1:0] hit_data, head_data, wr_data;
  logic [ADDR_W-1:0] head_addr;
  logic              accept, push, pop, launch_rd, launch_wr;

`ifdef L2WB_COALESCE_EN
  logic coal_hit, coal_head, ovr, head_busy;

  assign req_ready = !rd_pend && (!full || (req_we && coal_hit));
  assign head_busy = (state == ST_WR);
  assign ovr       = accept && req_we && coal_hit;
  assign push      = accept && req_we && !coal_hit;
`else
  assign req_ready = !rd_pend && !full;
  assign push      = accept && req_we;
`endif
  assign accept = req_valid && req_ready;

  wb_fifo_cam #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_cam (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_addr  (req_addr),
    .push_data  (req_wdata),
    .pop        (pop),
    .match_addr (req_addr),
`ifdef L2WB_COALESCE_EN
    .head_busy  (head_busy),
    .ovr        (ovr),
    .ovr_data   (req_wdata),
    .coal_hit   (coal_hit),
    .coal_head  (coal_head),
`endif
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .count      (count),
    .hit        (hit),
    .hit_data   (hit_data)
  );

  // A head overwritten on the same edge it launches must go out with the new data.
  always_comb begin
    wr_data = head_data;
`ifdef L2WB_COALESCE_EN
    if (ovr && coal_head) wr_data = req_wdata;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    launch_rd = 1'b0;
    launch_wr = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_pend) begin
          state_nx  = ST_RD;
          launch_rd = 1'b1;
        end else if (count != '0) begin
          state_nx  = ST_WR;
          launch_wr = 1'b1;
        end
      end
      ST_WR: begin
        if (mem_stb) begin
          state_nx = ST_IDLE;
          pop      = 1'b1;
        end
      end
      ST_RD:   if (mem_stb) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend     <= 1'b0;
      rd_addr     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      mem_addrstb <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept && !req_we) begin
        if (hit) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= hit_data;
        end else begin
          rd_pend <= 1'b1;
          rd_addr <= req_addr;
        end
      end
      if (state == ST_RD && mem_stb) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= mem_rdata;
        rd_pend   <= 1'b0;
      end
      if (launch_rd) begin
        mem_addrstb <= 1'b1;
        mem_we      <= 1'b0;
        mem_addr    <= rd_addr;
        mem_wdata   <= '0;
      end
      if (launch_wr) begin
        mem_addrstb <= 1'b1;
        mem_we      <= 1'b1;
        mem_addr    <= head_addr;
        mem_wdata   <= wr_data;
      end
      if ((state == ST_WR || state == ST_RD) && mem_stb) mem_addrstb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_l2_mem_write_buffer.sv
// Scoreboard bench for l2_mem_write_buffer: expected memory transactions and read responses
// are queued by the stimulus and popped by independent memory-model and response monitors.
module tb_l2_mem_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready, rsp_valid;
  logic [63:0] rsp_rdata;
  logic        mem_addrstb, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic        mem_stb;
  logic [2:0]  count;

  always #5 clk = ~clk;

  l2_mem_write_buffer #(.ADDR_W(32), .DATA_W(64), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .mem_addrstb (mem_addrstb),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_stb     (mem_stb),
    .count       (count)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] data;
  } mtx_t;

  typedef struct {
    int          kind;  // 0: forwarded (fixed cycle), 1: memory read (cycle after stb)
    logic [63:0] data;
    int          cyc;
  } rsp_t;

  mtx_t exp_mem[$];
  rsp_t exp_rsp[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rsp_seen = 0;

  bit          mem_hold = 1'b0;
  int          mem_lat = 3;
  logic [63:0] mem_rd_val = '0;
  bit          stray = 1'b0;
  bit          busy = 1'b0;
  bit          cur_we = 1'b0;
  int          cnt = 0;
  int          stb_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic mtx_t mk(input logic we, input logic [31:0] a, input logic [63:0] d);
    mtx_t m;
    m.we = we; m.addr = a; m.data = d;
    return m;
  endfunction

  // Memory model: checks each new transaction against the queue, answers after mem_lat cycles.
  initial begin
    mtx_t e;
    mem_stb   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy    = 1'b0;
        mem_stb = 1'b0;
      end else if (mem_stb) begin
        mem_stb = 1'b0;
        if (busy) begin
          busy = 1'b0;
          chk("addrstb_gap", 64'(mem_addrstb), 64'd0);
        end
      end else if (stray) begin
        mem_stb = 1'b1;
        stray   = 1'b0;
      end else if (!busy && mem_addrstb) begin
        if (exp_mem.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL mem_unexpected: got we=%0b addr=%h, required no transaction", mem_we, mem_addr);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_we", 64'(mem_we), 64'(e.we));
          chk("mem_addr", 64'(mem_addr), 64'(e.addr));
          if (e.we) chk("mem_wdata", mem_wdata, e.data);
        end
        busy   = 1'b1;
        cur_we = mem_we;
        cnt    = mem_lat;
      end else if (busy && !mem_hold) begin
        if (cnt > 1) cnt--;
        else begin
          mem_stb   = 1'b1;
          stb_cyc   = cyc;
          mem_rdata = cur_we ? 64'd0 : mem_rd_val;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_seen++;
        if (exp_rsp.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rsp_unexpected: got rdata=%h, required no response", rsp_rdata);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_rdata", rsp_rdata, e.data);
          chk("rsp_cycle", 64'(cyc), 64'((e.kind == 0) ? e.cyc : stb_cyc + 1));
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [63:0] d,
                       input int kind, input logic [63:0] rexp);
    int   n;
    logic acc;
    rsp_t r;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    n = 0;
    forever begin
      #1;
      acc = req_ready;
      if (acc && !we) begin
        r.kind = kind; r.data = rexp; r.cyc = cyc + 1;
        exp_rsp.push_back(r);
      end
      @(negedge clk);
      if (acc) break;
      n++;
      if (n > 300) begin
        chk("accept_timeout", 64'(acc), 64'd1);
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((count != 0 || mem_addrstb || busy || exp_mem.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 64'(n < 500), 64'd1);
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_seen < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_count", 64'(rsp_seen), 64'(target));
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset / idle state
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_addrstb", 64'(mem_addrstb), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);

    // Two posted writes drained in order
    mem_lat = 3;
    exp_mem.push_back(mk(1'b1, 32'h100, 64'hAA));
    exp_mem.push_back(mk(1'b1, 32'h108, 64'hBB));
    issue(1'b1, 32'h100, 64'hAA, 0, 64'd0);
    issue(1'b1, 32'h108, 64'hBB, 0, 64'd0);
    chk("two_wr_count", 64'(count), 64'd2);
    wait_drain();
    chk("two_wr_count_end", 64'(count), 64'd0);

    // Duplicate address writes and forwarding of the youngest data
    mem_hold = 1'b1;
`ifdef L2WB_COALESCE_EN
    exp_mem.push_back(mk(1'b1, 32'h200, 64'h22));
`else
    exp_mem.push_back(mk(1'b1, 32'h200, 64'h11));
    exp_mem.push_back(mk(1'b1, 32'h200, 64'h22));
`endif
    issue(1'b1, 32'h200, 64'h11, 0, 64'd0);
    issue(1'b1, 32'h200, 64'h22, 0, 64'd0);
`ifdef L2WB_COALESCE_EN
    chk("dup_count", 64'(count), 64'd1);
`else
    chk("dup_count", 64'(count), 64'd2);
`endif
    issue(1'b0, 32'h200, 64'd0, 0, 64'h22);
    @(negedge clk);
    chk("fwd_rsp_seen", 64'(rsp_seen), 64'd1);
    mem_hold = 1'b0;
    wait_drain();

    // Fill to DEPTH while memory stalls; fifth write waits for the first pop
    mem_hold = 1'b1;
    for (int i = 0; i < 5; i++)
      exp_mem.push_back(mk(1'b1, 32'h400 + 32'(8 * i), 64'(i + 1)));
    for (int i = 0; i < 4; i++)
      issue(1'b1, 32'h400 + 32'(8 * i), 64'(i + 1), 0, 64'd0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(req_ready), 64'd0);
    fork
      issue(1'b1, 32'h420, 64'd5, 0, 64'd0);
      begin
        repeat (6) @(negedge clk);
        chk("full_hold_count", 64'(count), 64'd4);
        chk("full_hold_valid", 64'(req_valid), 64'd1);
        mem_hold = 1'b0;
      end
    join
    chk("full_after_count", 64'(count), 64'd4);
    wait_drain();

    // Read miss overtakes queued drain
    mem_hold   = 1'b1;
    mem_rd_val = 64'hDEAD;
    exp_mem.push_back(mk(1'b1, 32'h500, 64'h55));
    exp_mem.push_back(mk(1'b0, 32'h300, 64'd0));
    exp_mem.push_back(mk(1'b1, 32'h508, 64'h66));
    issue(1'b1, 32'h500, 64'h55, 0, 64'd0);
    issue(1'b1, 32'h508, 64'h66, 0, 64'd0);
    issue(1'b0, 32'h300, 64'd0, 1, 64'hDEAD);
    chk("miss_ready", 64'(req_ready), 64'd0);
    mem_hold = 1'b0;
    wait_rsp(2);
    wait_drain();
    chk("miss_count_end", 64'(count), 64'd0);

    // Reset during a write transaction, then a stray strobe
    mem_hold = 1'b1;
    exp_mem.push_back(mk(1'b1, 32'h600, 64'h77));
    issue(1'b1, 32'h600, 64'h77, 0, 64'd0);
    begin
      int n;
      n = 0;
      while (!mem_addrstb && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("wr_launched", 64'(mem_addrstb), 64'd1);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_addrstb", 64'(mem_addrstb), 64'd0);
    chk("rst_mid_count", 64'(count), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    exp_mem.delete();
    mem_hold = 1'b0;
    @(negedge clk);
    stray = 1'b1;
    repeat (4) @(negedge clk);
    chk("stray_count", 64'(count), 64'd0);
    chk("stray_addrstb", 64'(mem_addrstb), 64'd0);
    chk("stray_ready", 64'(req_ready), 64'd1);

    repeat (3) @(negedge clk);
    chk("rsp_queue_left", 64'(exp_rsp.size()), 64'd0);
    chk("mem_queue_left", 64'(exp_mem.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
